// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants, state type and decode helper for fetch.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [15:0] NOP_INSTR       = 16'h0000;
  localparam logic [1:0]  TWO_WORD_PREFIX = 2'b11;
  localparam int          PREFIX_HI       = 15;
  localparam int          PREFIX_LO       = 14;

  typedef enum logic [0:0] {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } fetch_state_t;

  // An opcode word whose top two bits carry the prefix is followed by an immediate word.
  function automatic logic is_two_word(input logic [15:0] word);
    return (word[PREFIX_HI:PREFIX_LO] == TWO_WORD_PREFIX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : Pipeline register with flush (bubble) > hold > load priority.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module if_id_reg
  import fetch_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              hold,
  input  logic              bubble,
  input  logic [DATA_W-1:0] d_instruction,
  input  logic [DATA_W-1:0] d_immediate,
  input  logic [ADDR_W-1:0] d_pc_next,
  output logic              valid,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] immediate,
  output logic [ADDR_W-1:0] pc_next
);

  logic              r_valid;
  logic [DATA_W-1:0] r_instruction;
  logic [DATA_W-1:0] r_immediate;
  logic [ADDR_W-1:0] r_pc_next;

  // A cycle that neither holds nor loads leaves a bubble behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_instruction <= DATA_W'(NOP_INSTR);
      r_immediate   <= '0;
      r_pc_next     <= '0;
    end else if (bubble) begin
      r_valid       <= 1'b0;
      r_instruction <= DATA_W'(NOP_INSTR);
      r_immediate   <= '0;
      r_pc_next     <= '0;
    end else if (hold) begin
      r_valid       <= r_valid;
      r_instruction <= r_instruction;
      r_immediate   <= r_immediate;
      r_pc_next     <= r_pc_next;
    end else if (load) begin
      r_valid       <= 1'b1;
      r_instruction <= d_instruction;
      r_immediate   <= d_immediate;
      r_pc_next     <= d_pc_next;
    end else begin
      r_valid       <= 1'b0;
      r_instruction <= DATA_W'(NOP_INSTR);
      r_immediate   <= '0;
      r_pc_next     <= '0;
    end
  end

  assign valid       = r_valid;
  assign instruction = r_instruction;
  assign immediate   = r_immediate;
  assign pc_next     = r_pc_next;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Owns the PC, addresses imem and assembles one/two-word
//               instructions into the IF/ID register.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instruction,
  output logic [DATA_W-1:0] if_id_immediate,
  output logic [ADDR_W-1:0] if_id_pc_next
);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [DATA_W-1:0] r_op_hold;
  logic              w_two_word;
  logic              w_load;
  logic [DATA_W-1:0] w_d_instruction;
  logic [DATA_W-1:0] w_d_immediate;

  assign imem_addr  = r_pc;
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_two_word = is_two_word(imem_data[15:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH_OP;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect) begin
      w_next_state = FETCH_OP;
    end else if (!stall) begin
      case (r_state)
        FETCH_OP:  w_next_state = w_two_word ? FETCH_IMM : FETCH_OP;
        FETCH_IMM: w_next_state = FETCH_OP;
        default:   w_next_state = FETCH_OP;
      endcase
    end
  end

  // In FETCH_IMM the current word is always data, whatever its prefix bits.
  always_comb begin
    w_load          = 1'b0;
    w_d_instruction = DATA_W'(NOP_INSTR);
    w_d_immediate   = '0;
    case (r_state)
      FETCH_OP: begin
        if (!w_two_word) begin
          w_load          = 1'b1;
          w_d_instruction = imem_data;
        end
      end
      FETCH_IMM: begin
        w_load          = 1'b1;
        w_d_instruction = r_op_hold;
        w_d_immediate   = imem_data;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_op_hold <= '0;
    end else if (redirect) begin
      r_pc      <= redirect_pc;
      r_op_hold <= '0;
    end else if (!stall) begin
      r_pc <= w_pc_inc;
      if (r_state == FETCH_OP && w_two_word) begin
        r_op_hold <= imem_data;
      end
    end
  end

  if_id_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_if_id_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (w_load),
    .hold          (stall),
    .bubble        (redirect),
    .d_instruction (w_d_instruction),
    .d_immediate   (w_d_immediate),
    .d_pc_next     (w_pc_inc),
    .valid         (if_id_valid),
    .instruction   (if_id_instruction),
    .immediate     (if_id_immediate),
    .pc_next       (if_id_pc_next)
  );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage against a reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        if_id_valid;
  logic [15:0] if_id_instruction;
  logic [15:0] if_id_immediate;
  logic [15:0] if_id_pc_next;

  logic [15:0] mem [0:65535];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_stage #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_immediate   (if_id_immediate),
    .if_id_pc_next     (if_id_pc_next)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: "pending" means an opcode word is waiting for its immediate.
  logic [15:0] m_pc;
  logic [15:0] m_op;
  bit          m_pending;
  logic        m_valid;
  logic [15:0] m_instr;
  logic [15:0] m_imm;
  logic [15:0] m_pcn;

  logic [64:0] obs;
  logic [64:0] exp;
  assign obs = {imem_addr, if_id_valid, if_id_instruction, if_id_immediate, if_id_pc_next};
  assign exp = {m_pc, m_valid, m_instr, m_imm, m_pcn};

  task automatic model_bubble();
    m_valid = 1'b0;
    m_instr = 16'h0000;
    m_imm   = 16'h0000;
    m_pcn   = 16'h0000;
  endtask

  task automatic model_reset();
    m_pc      = 16'h0000;
    m_op      = 16'h0000;
    m_pending = 1'b0;
    model_bubble();
  endtask

  task automatic model_step();
    logic [15:0] word;
    word = mem[m_pc];
    if (redirect) begin
      m_pc      = redirect_pc;
      m_pending = 1'b0;
      model_bubble();
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_pending) begin
      m_valid   = 1'b1;
      m_instr   = m_op;
      m_imm     = word;
      m_pcn     = m_pc + 16'd1;
      m_pc      = m_pc + 16'd1;
      m_pending = 1'b0;
    end else if (word >= 16'hC000) begin
      m_op      = word;
      m_pending = 1'b1;
      m_pc      = m_pc + 16'd1;
      model_bubble();
    end else begin
      m_valid = 1'b1;
      m_instr = word;
      m_imm   = 16'h0000;
      m_pcn   = m_pc + 16'd1;
      m_pc    = m_pc + 16'd1;
    end
  endtask

  task automatic cycle(input bit st, input bit rd, input logic [15:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    model_reset();
    #1;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_t0: got %h want %h", obs, exp); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL reset_release: got %h want %h", obs, exp); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 16'h0000);
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL seq[%0d]: got %h want %h", i, obs, exp); end
    end
    n_vec++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_next} !== {16'd3, 1'b1, 16'h0A01, 16'd3}) begin
      n_err++;
      $display("FAIL seq_const: got addr=%h v=%b ins=%h pcn=%h want 0003/1/0a01/0003",
               imem_addr, if_id_valid, if_id_instruction, if_id_pc_next);
    end
  endtask

  task automatic test_two_word();
    cycle(1'b0, 1'b1, 16'h0004);
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL tw_redirect: got %h want %h", obs, exp); end
    cycle(1'b0, 1'b0, 16'h0000);
    n_vec++;
    if ({imem_addr, if_id_valid} !== {16'd5, 1'b0} || obs !== exp) begin
      n_err++; $display("FAIL tw_bubble: got %h want %h", obs, exp);
    end
    cycle(1'b0, 1'b0, 16'h0000);
    n_vec++;
    if ({if_id_valid, if_id_instruction, if_id_immediate, if_id_pc_next} !== {1'b1, 16'hC100, 16'h00FF, 16'd6}
        || obs !== exp) begin
      n_err++; $display("FAIL tw_complete: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_stall();
    cycle(1'b0, 1'b1, 16'h0001);
    cycle(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h0000);
      n_vec++;
      if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_next} !== {16'd2, 1'b1, 16'h2345, 16'd2}
          || obs !== exp) begin
        n_err++; $display("FAIL stall_op[%0d]: got %h want %h", i, obs, exp);
      end
    end
    cycle(1'b0, 1'b1, 16'h0010);
    cycle(1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h0000);
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL stall_imm[%0d]: got %h want %h", i, obs, exp); end
    end
    cycle(1'b0, 1'b0, 16'h0000);
    n_vec++;
    if ({if_id_valid, if_id_instruction, if_id_immediate, if_id_pc_next} !== {1'b1, 16'hC2AA, 16'hF00D, 16'h0012}
        || obs !== exp) begin
      n_err++; $display("FAIL stall_release: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_redirect_in_imm();
    cycle(1'b0, 1'b1, 16'h0020);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b1, 16'h0040);
    n_vec++;
    if ({imem_addr, if_id_valid} !== {16'h0040, 1'b0} || obs !== exp) begin
      n_err++; $display("FAIL redir_imm: got %h want %h", obs, exp);
    end
    cycle(1'b0, 1'b0, 16'h0000);
    n_vec++;
    if ({if_id_valid, if_id_instruction, if_id_immediate, if_id_pc_next} !== {1'b1, 16'h0ABC, 16'h0000, 16'h0041}
        || obs !== exp) begin
      n_err++; $display("FAIL redir_target: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_wrap();
    mem[16'hFFFF] = 16'h1111;
    cycle(1'b0, 1'b1, 16'hFFFF);
    cycle(1'b0, 1'b0, 16'h0000);
    n_vec++;
    if ({imem_addr, if_id_valid, if_id_instruction, if_id_pc_next} !== {16'h0000, 1'b1, 16'h1111, 16'h0000}
        || obs !== exp) begin
      n_err++; $display("FAIL wrap_single: got %h want %h", obs, exp);
    end
    mem[16'hFFFF] = 16'hC0AB;
    cycle(1'b0, 1'b1, 16'hFFFF);
    cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0000);
    n_vec++;
    if ({if_id_valid, if_id_instruction, if_id_immediate, if_id_pc_next} !== {1'b1, 16'hC0AB, 16'h1234, 16'h0001}
        || obs !== exp) begin
      n_err++; $display("FAIL wrap_two_word: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 16'h0010);
    cycle(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (obs !== exp) begin n_err++; $display("FAIL async_reset: got %h want %h", obs, exp); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 1'b0, 16'h0000);
    n_vec++;
    if ({if_id_valid, if_id_instruction, if_id_immediate, if_id_pc_next} !== {1'b1, 16'h1234, 16'h0000, 16'h0001}
        || obs !== exp) begin
      n_err++; $display("FAIL async_restart: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_random();
    for (int a = 16'h0100; a < 16'h0200; a++) begin
      mem[a] = 16'($urandom);
    end
    cycle(1'b0, 1'b1, 16'h0100);
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
            16'($urandom_range(16'h0100, 16'h01F0)));
      n_vec++;
      if (obs !== exp) begin n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp); end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[0]     = 16'h1234;
    mem[1]     = 16'h2345;
    mem[2]     = 16'h0A01;
    mem[4]     = 16'hC100;
    mem[5]     = 16'h00FF;
    mem[16]    = 16'hC2AA;
    mem[17]    = 16'hF00D;
    mem[32]    = 16'hC003;
    mem[64]    = 16'h0ABC;

    test_reset();
    test_sequential();
    test_two_word();
    test_stall();
    test_redirect_in_imm();
    test_wrap();
    test_async_reset();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
